// File: rtl/gpmc_bus_ctrl_pkg.sv
// Shared types and default parameters for the GPMC host-to-register-bus controller.
package gpmc_bus_ctrl_pkg;

    localparam int             DEF_ADDR_WIDTH = 16;
    localparam int             DEF_DATA_WIDTH = 16;
    localparam int             DEF_NUM_SLAVES = 4;
    localparam int             DEF_SLAVE_BITS = 2;
    localparam int             DEF_TIMEOUT    = 15;
    localparam logic [15:0]    DEF_ERR_DATA   = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STROBE   = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

endpackage

// File: rtl/gpmc_bus_ctrl_if.sv
// Register-bus side of the controller: one-hot select, strobes, per-slave ack and read data.
interface gpmc_bus_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_SLAVES = 4,
    parameter int SLAVE_BITS = 2
);
    logic [NUM_SLAVES-1:0]            slv_sel;
    logic [ADDR_WIDTH-SLAVE_BITS-1:0] slv_addr;
    logic [DATA_WIDTH-1:0]            slv_wdata;
    logic                             slv_wr;
    logic                             slv_rd;
    logic [NUM_SLAVES-1:0]            slv_ack;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_rdata;

    modport master (
        output slv_sel, slv_addr, slv_wdata, slv_wr, slv_rd,
        input  slv_ack, slv_rdata
    );

    modport slave (
        input  slv_sel, slv_addr, slv_wdata, slv_wr, slv_rd,
        output slv_ack, slv_rdata
    );
endinterface

// File: rtl/gpmc_bus_ctrl_addr_decode.sv
// Splits a host address into slave index, one-hot select and in-region offset (combinational).
module gpmc_addr_decode #(
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_SLAVES = 4,
    parameter int SLAVE_BITS = 2
) (
    input  logic [ADDR_WIDTH-1:0]            address,
    output logic [SLAVE_BITS-1:0]            idx,
    output logic [NUM_SLAVES-1:0]            sel,
    output logic [ADDR_WIDTH-SLAVE_BITS-1:0] offset
);
    assign idx    = address[ADDR_WIDTH-1 -: SLAVE_BITS];
    assign offset = address[ADDR_WIDTH-SLAVE_BITS-1:0];

    always_comb begin
        sel      = '0;
        sel[idx] = 1'b1;
    end
endmodule

// File: rtl/gpmc_bus_ctrl.sv
// Sequences one host access per chip-select cycle onto the register bus, with ack timeout,
// read-data hold and a saturating error counter.
module gpmc_bus_ctrl
    import gpmc_bus_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int                    SLAVE_BITS = DEF_SLAVE_BITS,
    parameter int                    TIMEOUT    = DEF_TIMEOUT,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DEF_ERR_DATA
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  csn,
    input  logic                  oen,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    gpmc_bus_ctrl_if.master       bus,
    output logic                  busy,
    output logic [7:0]            err_count
);
    state_t                           state, state_nxt;
    logic [7:0]                       cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0]            rdata_q;
    logic [7:0]                       err_q;
    logic [NUM_SLAVES-1:0]            sel_q;
    logic [ADDR_WIDTH-SLAVE_BITS-1:0] addr_q;
    logic [DATA_WIDTH-1:0]            wdata_q;
    logic                             dir_wr_q;
    logic [SLAVE_BITS-1:0]            idx_q;

    logic [SLAVE_BITS-1:0]            dec_idx;
    logic [NUM_SLAVES-1:0]            dec_sel;
    logic [ADDR_WIDTH-SLAVE_BITS-1:0] dec_offset;

    logic load, capture, load_err_data, err_inc, sel_ack;

    gpmc_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BITS (SLAVE_BITS)
    ) u_decode (
        .address (address),
        .idx     (dec_idx),
        .sel     (dec_sel),
        .offset  (dec_offset)
    );

    assign sel_ack = bus.slv_ack[idx_q];

    // csn release is checked before ack so an ack racing an abort is dropped.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        load          = 1'b0;
        capture       = 1'b0;
        load_err_data = 1'b0;
        err_inc       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!csn) begin
                    if (!wen && !oen) begin
                        err_inc       = 1'b1;
                        load_err_data = 1'b1;
                        state_nxt     = ST_HOLD;
                    end else if (!wen || !oen) begin
                        load      = 1'b1;
                        state_nxt = ST_STROBE;
                    end
                end
            end
            ST_STROBE: begin
                cnt_nxt = 8'd0;
                if (csn) begin
                    state_nxt = ST_IDLE;
                end else if (sel_ack) begin
                    capture   = !dir_wr_q;
                    state_nxt = ST_HOLD;
                end else begin
                    state_nxt = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                cnt_nxt = cnt + 8'd1;
                if (csn) begin
                    state_nxt = ST_IDLE;
                end else if (sel_ack) begin
                    capture   = !dir_wr_q;
                    state_nxt = ST_HOLD;
                end else if (cnt_nxt == 8'(TIMEOUT)) begin
                    err_inc       = 1'b1;
                    load_err_data = !dir_wr_q;
                    state_nxt     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (csn) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= 8'd0;
            rdata_q  <= '0;
            err_q    <= 8'd0;
            sel_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            dir_wr_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) begin
                sel_q    <= dec_sel;
                addr_q   <= dec_offset;
                wdata_q  <= wdata;
                dir_wr_q <= !wen;
                idx_q    <= dec_idx;
            end else if (state_nxt != ST_STROBE && state_nxt != ST_WAIT_ACK) begin
                sel_q <= '0;
            end
            if (load_err_data) begin
                rdata_q <= ERR_DATA;
            end else if (capture) begin
                rdata_q <= bus.slv_rdata[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
        end
    end

    assign bus.slv_sel   = sel_q;
    assign bus.slv_addr  = addr_q;
    assign bus.slv_wdata = wdata_q;
    assign bus.slv_wr    = (state == ST_STROBE) &&  dir_wr_q;
    assign bus.slv_rd    = (state == ST_STROBE) && !dir_wr_q;
    assign busy          = (state != ST_IDLE);
    assign rdata         = rdata_q;
    assign err_count     = err_q;
endmodule

// File: tb/tb_gpmc_bus_ctrl.sv
// Randomised bench for gpmc_bus_ctrl against a transaction-level outcome model.
module tb_gpmc_bus_ctrl;
    localparam int T   = 15;
    localparam int RUN = T + 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        csn = 1'b1, oen = 1'b1, wen = 1'b1;
    logic [15:0] address = '0, wdata = '0;
    logic [15:0] rdata;
    logic        busy;
    logic [7:0]  err_count;

    gpmc_bus_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .NUM_SLAVES(4), .SLAVE_BITS(2)) bus ();

    gpmc_bus_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .csn       (csn),
        .oen       (oen),
        .wen       (wen),
        .address   (address),
        .wdata     (wdata),
        .rdata     (rdata),
        .bus       (bus),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_rdata  = '0;
    logic [7:0]  m_err    = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // d: cycle (relative to the strobe cycle) of the selected ack pulse, > T means never.
    // a: first cycle with csn released, large means no abort. force_data < 0: random read data.
    task automatic run_txn(input bit proto, input bit wr, input logic [15:0] addr,
                           input logic [15:0] wd, input int d, input int a, input int force_data);
        logic [1:0]  idx    = addr[15:14];
        logic [3:0]  onehot = 4'b0001 << idx;
        logic [15:0] v[4];
        logic [15:0] cap = '0;
        int          end_cyc;
        int          kind;   // 0 proto, 1 abort, 2 ack, 3 timeout
        int          nstrobe = 0;
        bit          both = 0;
        logic [15:0] exp_rdata;
        logic [7:0]  exp_err;
        bit          exp_busy;

        if (proto)                  begin kind = 0; end_cyc = -1; end
        else if (a <= d && a <= T)  begin kind = 1; end_cyc = a;  end
        else if (d <= T)            begin kind = 2; end_cyc = d;  end
        else                        begin kind = 3; end_cyc = T;  end

        @(negedge clk);
        csn = 1'b0; address = addr; wdata = wd;
        wen = !(proto || wr);
        oen = !(proto || !wr);
        bus.slv_ack = '0;

        for (int r = 0; r < RUN; r++) begin
            @(negedge clk);
            if (bus.slv_wr || bus.slv_rd) nstrobe++;
            if (bus.slv_wr && bus.slv_rd) both = 1;
            if (r == 0 && !proto) begin
                check_eq("strobe_wr",  {31'd0, bus.slv_wr}, {31'd0, wr});
                check_eq("strobe_rd",  {31'd0, bus.slv_rd}, {31'd0, !wr});
                check_eq("slv_sel",    {28'd0, bus.slv_sel}, {28'd0, onehot});
                check_eq("slv_addr",   {18'd0, bus.slv_addr}, {18'd0, addr[13:0]});
                check_eq("slv_wdata",  {16'd0, bus.slv_wdata}, {16'd0, wd});
            end
            if (r == end_cyc && !proto)
                check_eq("rdata_early", {16'd0, rdata}, {16'd0, m_rdata});
            if (r == end_cyc + 1) begin
                exp_rdata = m_rdata;
                exp_err   = m_err;
                exp_busy  = (kind != 1);
                if (kind == 0 || kind == 3) exp_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
                if (kind == 0 || (kind == 3 && !wr)) exp_rdata = 16'hDEAD;
                if (kind == 2 && !wr) exp_rdata = cap;
                check_eq("rdata",     {16'd0, rdata}, {16'd0, exp_rdata});
                check_eq("err_count", {24'd0, err_count}, {24'd0, exp_err});
                check_eq("busy_end",  {31'd0, busy}, {31'd0, exp_busy});
                check_eq("sel_clear", {28'd0, bus.slv_sel}, 32'd0);
                m_rdata = exp_rdata;
                m_err   = exp_err;
            end
            csn = (r >= a) ? 1'b1 : 1'b0;
            for (int s = 0; s < 4; s++) v[s] = 16'($urandom);
            if (r == d && force_data >= 0) v[idx] = 16'(force_data);
            if (r == d) cap = v[idx];
            bus.slv_rdata = {v[3], v[2], v[1], v[0]};
            bus.slv_ack   = (4'($urandom) & ~onehot) | ((r == d) ? onehot : 4'b0000);
        end

        check_eq("strobe_count", nstrobe, proto ? 32'd0 : 32'd1);
        check_eq("strobe_both",  {31'd0, both}, 32'd0);
        csn = 1'b1; wen = 1'b1; oen = 1'b1; bus.slv_ack = '0;
        @(negedge clk);
        @(negedge clk);
        check_eq("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        bus.slv_ack   = '0;
        bus.slv_rdata = '0;
        #12;
        check_eq("rst_rdata", {16'd0, rdata}, 32'd0);
        check_eq("rst_busy",  {31'd0, busy}, 32'd0);
        check_eq("rst_err",   {24'd0, err_count}, 32'd0);
        check_eq("rst_sel",   {28'd0, bus.slv_sel}, 32'd0);
        check_eq("rst_strb",  {30'd0, bus.slv_wr, bus.slv_rd}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_txn(0, 1, 16'h4012, 16'h1234, 0, 1000, -1);
        run_txn(0, 0, 16'hC004, 16'h0000, 3, 1000, 16'hBEEF);
        run_txn(0, 0, 16'h0100, 16'h0000, 99, 1000, -1);
        run_txn(1, 0, 16'h8000, 16'h5555, 99, 1000, -1);
        run_txn(0, 0, 16'h8020, 16'h0000, 6, 3, -1);
        run_txn(0, 1, 16'h2222, 16'hA5A5, T, 1000, -1);
        run_txn(0, 0, 16'h7FFF, 16'h0000, T, 1000, -1);
        run_txn(0, 0, 16'h4000, 16'h0000, 0, 0, -1);
        run_txn(0, 1, 16'hFFFF, 16'h0F0F, 99, 1000, -1);

        for (int i = 0; i < 60; i++) begin
            bit proto = ($urandom_range(0, 7) == 0);
            int a     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, T)) : 1000;
            run_txn(proto, 1'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, T + 3)), a, -1);
        end

        // Reset while a read is waiting for an ack.
        run_txn(1, 0, 16'h0000, 16'h0000, 99, 1000, -1);
        @(negedge clk);
        csn = 1'b0; oen = 1'b0; wen = 1'b1; address = 16'hC0DE; wdata = 16'h7777;
        bus.slv_ack = '0;
        repeat (4) @(negedge clk);
        check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check_eq("arst_rdata", {16'd0, rdata}, 32'd0);
        check_eq("arst_err",   {24'd0, err_count}, 32'd0);
        check_eq("arst_busy",  {31'd0, busy}, 32'd0);
        check_eq("arst_sel",   {28'd0, bus.slv_sel}, 32'd0);
        check_eq("arst_addr",  {18'd0, bus.slv_addr}, 32'd0);
        check_eq("arst_wdata", {16'd0, bus.slv_wdata}, 32'd0);
        check_eq("arst_strb",  {30'd0, bus.slv_wr, bus.slv_rd}, 32'd0);
        csn = 1'b1; oen = 1'b1;
        m_rdata = '0;
        m_err   = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 257; i++)
            run_txn(1, 0, 16'($urandom), 16'h0000, 99, 1000, -1);
        check_eq("err_saturate", {24'd0, err_count}, 32'h0000_00FF);

        run_txn(0, 0, 16'h0001, 16'h0000, 99, 1000, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
